// File: rtl/irig_pkg.sv
// rtl/irig_pkg.sv - shared states, symbol decode, field positions and field struct for the IRIG-B decoder
package irig_pkg;

  typedef enum logic [1:0] {UNLOCKED, PRELOCK, ACQUIRE, LOCKED} irig_state_t;

  typedef enum logic [2:0] {SYM_NONE, SYM_D0, SYM_D1, SYM_MARK, SYM_GARBAGE} irig_sym_t;

  // LSB positions of each BCD digit; the LSB is the earliest bit in the frame
  localparam int SEC_U_LSB  = 1;
  localparam int SEC_T_LSB  = 6;
  localparam int MIN_U_LSB  = 10;
  localparam int MIN_T_LSB  = 15;
  localparam int HOUR_U_LSB = 20;
  localparam int HOUR_T_LSB = 25;
  localparam int DAY_U_LSB  = 30;
  localparam int DAY_T_LSB  = 35;
  localparam int DAY_H_LSB  = 40;
  localparam int YEAR_U_LSB = 50;
  localparam int YEAR_T_LSB = 55;
  localparam int SBS_LO_LSB = 80;
  localparam int SBS_LO_W   = 9;
  localparam int SBS_HI_LSB = 90;
  localparam int SBS_HI_W   = 8;
  localparam int SBS_W      = SBS_LO_W + SBS_HI_W;

  typedef struct packed {
    logic [3:0]       sec_u;
    logic [2:0]       sec_t;
    logic [3:0]       min_u;
    logic [2:0]       min_t;
    logic [3:0]       hour_u;
    logic [1:0]       hour_t;
    logic [3:0]       day_u;
    logic [3:0]       day_t;
    logic [1:0]       day_h;
    logic [3:0]       year_u;
    logic [3:0]       year_t;
    logic [SBS_W-1:0] sbs;
  } irig_fields_t;

  // Simultaneous strobes cannot be trusted, so they collapse to garbage
  function automatic irig_sym_t decode_sym(input logic d0, input logic d1,
                                           input logic mark, input logic garbage);
    case ({d0, d1, mark, garbage})
      4'b0000: return SYM_NONE;
      4'b1000: return SYM_D0;
      4'b0100: return SYM_D1;
      4'b0010: return SYM_MARK;
      default: return SYM_GARBAGE;
    endcase
  endfunction

endpackage

// File: rtl/irig_frame_fields.sv
// rtl/irig_frame_fields.sv - combinational BCD/sbs extraction from the frame buffer; sbs only with IRIG_SBS_EN
module irig_frame_fields import irig_pkg::*; #(
  parameter int FRAME_POS = 100
) (
  input  logic [FRAME_POS-1:0] frame_buf,
  output irig_fields_t         fields
);

  always_comb begin
    fields        = '0;
    fields.sec_u  = frame_buf[SEC_U_LSB +: 4];
    fields.sec_t  = frame_buf[SEC_T_LSB +: 3];
    fields.min_u  = frame_buf[MIN_U_LSB +: 4];
    fields.min_t  = frame_buf[MIN_T_LSB +: 3];
    fields.hour_u = frame_buf[HOUR_U_LSB +: 4];
    fields.hour_t = frame_buf[HOUR_T_LSB +: 2];
    fields.day_u  = frame_buf[DAY_U_LSB +: 4];
    fields.day_t  = frame_buf[DAY_T_LSB +: 4];
    fields.day_h  = frame_buf[DAY_H_LSB +: 2];
    fields.year_u = frame_buf[YEAR_U_LSB +: 4];
    fields.year_t = frame_buf[YEAR_T_LSB +: 4];
`ifdef IRIG_SBS_EN
    fields.sbs    = {frame_buf[SBS_HI_LSB +: SBS_HI_W], frame_buf[SBS_LO_LSB +: SBS_LO_W]};
`else
    fields.sbs    = '0;
`endif
  end

  // Marker and control positions carry no field data
  logic unused_bits;
  assign unused_bits = ^frame_buf;

endmodule

// File: rtl/irig_frame_decoder.sv
// rtl/irig_frame_decoder.sv - IRIG-B frame decoder with lock tracking and PPS; IRIG_SBS_EN enables sbs
module irig_frame_decoder #(
  parameter int FRAME_POS   = 100,
  parameter int MARK_PERIOD = 10,
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irig_d0,
  input  logic             irig_d1,
  input  logic             irig_mark,
  input  logic             irig_garbage,
  output logic             pps,
  output logic             locked,
  output logic             frame_valid,
  output logic [3:0]       sec_u,
  output logic [2:0]       sec_t,
  output logic [3:0]       min_u,
  output logic [2:0]       min_t,
  output logic [3:0]       hour_u,
  output logic [1:0]       hour_t,
  output logic [3:0]       day_u,
  output logic [3:0]       day_t,
  output logic [1:0]       day_h,
  output logic [3:0]       year_u,
  output logic [3:0]       year_t,
  output logic [16:0]      sbs,
  output logic [ERR_W-1:0] err_cnt
);
  import irig_pkg::*;

  localparam int                POS_W    = $clog2(FRAME_POS);
  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(FRAME_POS - 1);
  localparam logic [3:0]        LOCK_N   = 4'(LOCK_FRAMES);

  function automatic logic [FRAME_POS-1:0] marker_mask();
    logic [FRAME_POS-1:0] m;
    m    = '0;
    m[0] = 1'b1;
    for (int p = MARK_PERIOD - 1; p < FRAME_POS; p += MARK_PERIOD) m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [FRAME_POS-1:0] sbs_mask();
    logic [FRAME_POS-1:0] m;
    m = '0;
    for (int p = SBS_LO_LSB; p < SBS_LO_LSB + SBS_LO_W + 1 + SBS_HI_W; p++) m[p] = 1'b1;
    return m;
  endfunction

  localparam logic [FRAME_POS-1:0] MARK_MASK = marker_mask();
`ifdef IRIG_SBS_EN
  localparam logic [FRAME_POS-1:0] STORE_MASK = '1;
`else
  localparam logic [FRAME_POS-1:0] STORE_MASK = ~sbs_mask();
`endif

  irig_state_t          state, state_n;
  irig_sym_t            sym;
  logic [POS_W-1:0]     pos, pos_n, cur;
  logic [3:0]           good_cnt, good_n, good_inc;
  logic [ERR_W-1:0]     err_n;
  logic                 wr_en, frame_end, pps_n, is_mark_pos;
  logic [FRAME_POS-1:0] frame_buf;
  irig_fields_t         fields_c, fields_q;

  assign sym         = decode_sym(irig_d0, irig_d1, irig_mark, irig_garbage);
  // pos holds the position of the last accepted symbol; cur is where this one lands
  assign cur         = (pos == LAST_POS) ? '0 : pos + 1'b1;
  assign is_mark_pos = MARK_MASK[cur];
  assign good_inc    = (good_cnt == 4'hF) ? good_cnt : good_cnt + 1'b1;

  always_comb begin
    state_n   = state;
    pos_n     = pos;
    good_n    = good_cnt;
    err_n     = err_cnt;
    wr_en     = 1'b0;
    frame_end = 1'b0;
    pps_n     = 1'b0;
    if (sym != SYM_NONE) begin
      case (state)
        UNLOCKED: if (sym == SYM_MARK) state_n = PRELOCK;
        PRELOCK: begin
          if (sym == SYM_MARK) begin
            state_n = ACQUIRE;
            pos_n   = '0;
            good_n  = '0;
          end else begin
            state_n = UNLOCKED;
          end
        end
        default: begin
          if (sym == SYM_GARBAGE || ((sym == SYM_MARK) != is_mark_pos)) begin
            state_n = UNLOCKED;
            pos_n   = '0;
            good_n  = '0;
            if (err_cnt != '1) err_n = err_cnt + 1'b1;
          end else begin
            pos_n = cur;
            wr_en = 1'b1;
            if (sym == SYM_MARK && cur == '0) pps_n = (state == LOCKED);
            if (sym == SYM_MARK && cur == LAST_POS) begin
              frame_end = 1'b1;
              good_n    = good_inc;
              if (good_inc >= LOCK_N) state_n = LOCKED;
            end
          end
        end
      endcase
    end
  end

  irig_frame_fields #(.FRAME_POS(FRAME_POS)) u_fields (
    .frame_buf (frame_buf),
    .fields    (fields_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNLOCKED;
      pos         <= '0;
      good_cnt    <= '0;
      err_cnt     <= '0;
      pps         <= 1'b0;
      frame_valid <= 1'b0;
      frame_buf   <= '0;
      fields_q    <= '0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      good_cnt    <= good_n;
      err_cnt     <= err_n;
      pps         <= pps_n;
      frame_valid <= frame_end;
      if (wr_en && STORE_MASK[cur]) frame_buf[cur] <= (sym == SYM_D1);
      if (frame_end) fields_q <= fields_c;
    end
  end

  assign locked = (state == LOCKED);
  assign sec_u  = fields_q.sec_u;
  assign sec_t  = fields_q.sec_t;
  assign min_u  = fields_q.min_u;
  assign min_t  = fields_q.min_t;
  assign hour_u = fields_q.hour_u;
  assign hour_t = fields_q.hour_t;
  assign day_u  = fields_q.day_u;
  assign day_t  = fields_q.day_t;
  assign day_h  = fields_q.day_h;
  assign year_u = fields_q.year_u;
  assign year_t = fields_q.year_t;
  assign sbs    = fields_q.sbs;

endmodule

// File: doc/irig_frame_decoder.md
# irig_frame_decoder

Full-frame IRIG-B time-code decoder with lock tracking, frame error detection and a locked PPS output. Sits directly after the IRIG symbol classifier, which supplies one-cycle d0/d1/mark/garbage strobes. Stores a complete 100-position frame, checks the marker pattern, and extracts BCD time fields, including year. On every error-free frame it updates the registered time outputs atomically.

## Interface
- FRAME_POS, 100: positions per frame, P0 at FRAME_POS-1.
- MARK_PERIOD, 10: spacing of position markers; markers are required at positions 0 and k*MARK_PERIOD-1.
- LOCK_FRAMES, 2: number of consecutive error-free frames needed to enter LOCKED (1..15).
- ERR_W, 8: width of the saturating error counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised upstream.
- irig_d0  in  1  one-cycle strobe: data bit 0.
- irig_d1  in  1  one-cycle strobe: data bit 1.
- irig_mark  in  1  one-cycle strobe: marker symbol.
- irig_garbage  in  1  one-cycle strobe: unclassifiable symbol.
- pps  out  1  one-cycle pulse on reference marker Pr, only while LOCKED.
- locked  out  1  high in LOCKED.
- frame_valid  out  1  one-cycle pulse when the field outputs update.
- sec_u/min_u/hour_u/day_u/year_u/year_t  out  4 each  BCD digits.
- sec_t/min_t  out  3 each  BCD tens digits.
- hour_t/day_h  out  2 each  BCD tens and hundreds digits.
- day_t  out  4  BCD day tens.
- sbs  out  17  straight-binary seconds of day (see Configuration).
- err_cnt  out  ERR_W  count of frame errors, saturating at all-ones.

## Operation
- Symbol is any strobe.
- More than one strobe high in the same cycle is treated as garbage.
- States:
  - UNLOCKED: a mark moves to PRELOCK.
  - PRELOCK: a mark moves to ACQUIRE and sets pos=0, so the second consecutive mark is Pr. A d0, d1 or garbage returns to UNLOCKED.
  - ACQUIRE: receives frames and tracks good_cnt.
  - LOCKED: locked=1.
- Position counter pos advances by 1 per symbol and wraps from FRAME_POS-1 to 0.
- Data bit at a non-marker position is written to the frame buffer at [pos]. Marker positions store 0.
- Frame error, in ACQUIRE or LOCKED, is any of:
  - garbage;
  - mark at a non-marker position;
  - d0/d1 at a marker position.
- On a frame error: err_cnt+1 (saturating), good_cnt=0, next state UNLOCKED, no field update. A frame error in LOCKED drops locked the next cycle.
- Frame end is a mark at pos=FRAME_POS-1 (P0) with no error since the last Pr. At frame end:
  - latch all fields from the buffer;
  - pulse frame_valid;
  - good_cnt+1;
  - enter LOCKED when good_cnt reaches LOCK_FRAMES.
- Field positions: sec 1-4/6-8, min 10-13/15-17, hour 20-23/25-26, day 30-33/35-38/40-41, year 50-53/55-58, sbs 80-88,90-97. LSB is first in time.
- Fields describe the Pr that opened the latched frame. No BCD range check.
- pps fires on the Pr mark (pos 0) only while LOCKED, including the Pr immediately after the frame that achieved lock.

## Timing
- All outputs are registered, one cycle after the causing strobe:
  - pps follows the Pr strobe by 1 cycle;
  - frame_valid and the fields update 1 cycle after the P0 strobe.
- Strobes are accepted every cycle; back-to-back symbols are legal.
- Reset values: all outputs 0, state UNLOCKED, pos 0, good_cnt 0, buffer 0.
- rst_n asserted mid-frame clears state immediately and discards the partial frame. Latched fields are also cleared.
- The fields do not change between frame_valid pulses.

## Configuration
- IRIG_SBS_EN defined:
  - positions 80-97 are stored;
  - sbs is latched at frame end.
- Undefined:
  - those buffer bits are not implemented;
  - sbs is tied to 0;
  - marker checking at positions 89 and 99 is unchanged.

## Structure
- Package irig_pkg holds:
  - state enum (UNLOCKED, PRELOCK, ACQUIRE, LOCKED);
  - field position localparams;
  - symbol-decode constants.
- Sub-module irig_frame_fields: combinational extraction of the BCD digits and sbs from the frame buffer. Instantiated once; its outputs are registered in the parent at frame end.

## Test plan
- Two clean frames encoding 12:34:56, day 123, year 24, LOCK_FRAMES=2:
  - first P0 gives frame_valid with sec_u=6, sec_t=5, min_u=4, min_t=3, hour_u=2, hour_t=1, day_h=1, day_t=2, day_u=3, year_t=2, year_u=4, locked=0;
  - second P0 gives locked=1;
  - next Pr gives a pps pulse 1 cycle later.
- Mark injected at pos 5 while LOCKED: err_cnt 0→1, locked→0 next cycle, no frame_valid, no pps at the next Pr.
- d1 and mark strobed in the same cycle during ACQUIRE: counted as garbage, err_cnt+1, state UNLOCKED.
- rst_n pulsed low at pos 47 of a locked frame: all outputs 0 immediately. Relock requires two marks plus LOCK_FRAMES frames.
- With IRIG_SBS_EN, frame with sbs=45296: sbs=45296 after frame_valid. Without the macro: sbs=0.
- 256 consecutive garbage-terminated frames with ERR_W=8: err_cnt holds at 255.
